// File: rtl/dcache_wb_fifo_pkg.sv
// Shared widths, entry layout and address-build constant for the dcache write-back FIFO.
package dcache_wb_fifo_pkg;

    localparam int NUM_SET_BITS = 3;
    localparam int NUM_TAG_BITS = 10;
    localparam int FIFO_SIZE    = 8;

    // Low address bits below the block: blocks are 8 bytes, so always zero.
    localparam logic [2:0] BLOCK_OFFSET = 3'b000;

    typedef struct packed {
        logic [NUM_SET_BITS-1:0] index;
        logic [NUM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
    } wb_entry_t;

endpackage

// File: rtl/dcache_wb_fifo.sv
// Write-back FIFO feeding evicted dcache blocks to memory oldest-first.
// Define WB_FIFO_COALESCE_EN to merge writes that hit an already-queued {index, tag}.
module dcache_wb_fifo
    import dcache_wb_fifo_pkg::*;
#(
    parameter int  NUM_SET_BITS = dcache_wb_fifo_pkg::NUM_SET_BITS,
    parameter int  NUM_TAG_BITS = dcache_wb_fifo_pkg::NUM_TAG_BITS,
    parameter int  FIFO_SIZE    = dcache_wb_fifo_pkg::FIFO_SIZE,
    localparam int ENTRY_W      = NUM_SET_BITS + NUM_TAG_BITS + 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [NUM_SET_BITS-1:0]           wr_index,
    input  logic [NUM_TAG_BITS-1:0]           wr_tag,
    input  logic [63:0]                       wr_data,
    output logic                              wr_accept,
    output logic                              full,
    output logic                              empty,
    output logic [FIFO_SIZE-1:0][ENTRY_W-1:0] fifo_entries,
    output logic [FIFO_SIZE-1:0]              fifo_valid,
    output logic                              mem_valid,
    output logic [15:0]                       mem_addr,
    output logic [63:0]                       mem_data,
    input  logic                              mem_ready
);

    localparam int PTR_W = $clog2(FIFO_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [NUM_SET_BITS-1:0] index;
        logic [NUM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
    } entry_t;

    entry_t [FIFO_SIZE-1:0] slots;
    logic   [FIFO_SIZE-1:0] valid_q;
    logic   [PTR_W-1:0]     head;
    logic   [PTR_W-1:0]     tail;
    logic   [CNT_W-1:0]     count;
    logic   [CNT_W-1:0]     count_next;
    logic                   pop;
    logic                   push;
    logic                   coalesce;

    assign mem_valid    = !empty;
    assign pop          = mem_valid && mem_ready;
    assign mem_addr     = {slots[head].tag, slots[head].index, BLOCK_OFFSET};
    assign mem_data     = slots[head].data;
    assign fifo_entries = slots;
    assign fifo_valid   = valid_q;

`ifdef WB_FIFO_COALESCE_EN
    logic [PTR_W-1:0] hit_slot;
    logic [PTR_W-1:0] probe;

    // Youngest-first search; a head slot leaving this cycle cannot absorb the write.
    always_comb begin
        coalesce = 1'b0;
        hit_slot = '0;
        probe    = '0;
        for (int k = 0; k < FIFO_SIZE; k++) begin
            probe = tail - PTR_W'(k + 1);
            if (!coalesce && wr_en && valid_q[probe] &&
                slots[probe].index == wr_index && slots[probe].tag == wr_tag &&
                !(pop && probe == head)) begin
                coalesce = 1'b1;
                hit_slot = probe;
            end
        end
    end
`else
    assign coalesce = 1'b0;
`endif

    assign wr_accept  = wr_en && (coalesce || !full);
    assign push       = wr_en && !full && !coalesce;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            valid_q <= '0;
            // NOTE: the slot array is reset because dcache searches it directly and invalid slots must read as zero.
            slots   <= '0;
        end else begin
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_SIZE));
            empty <= (count_next == '0);
            if (pop) begin
                valid_q[head] <= 1'b0;
                slots[head]   <= '0;
                head          <= head + PTR_W'(1);
            end
`ifdef WB_FIFO_COALESCE_EN
            if (coalesce) begin
                slots[hit_slot].data <= wr_data;
            end
`endif
            if (push) begin
                slots[tail]   <= '{index: wr_index, tag: wr_tag, data: wr_data};
                valid_q[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/dcache_wb_fifo.md
Name: dcache_wb_fifo

Overview:
- Producer side of the dcache write-back FIFO.
- Accepts evicted or dirty 64-bit blocks tagged {index, tag}, stores them in a circular buffer, and drains them oldest-first to memory over a valid/ready handshake.
- Exposes its full entry array and a per-slot valid mask, in the {index, tag, data} packing that dcache searches.

Parameters:
- NUM_SET_BITS, 3, width of the cache set index.
- NUM_TAG_BITS, 10, width of the tag (NUM_SET_BITS + NUM_TAG_BITS = 13).
- FIFO_SIZE, 8, number of entries; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request this cycle.
- wr_index  in  NUM_SET_BITS  set index of the block.
- wr_tag  in  NUM_TAG_BITS  tag of the block.
- wr_data  in  64  block data.
- wr_accept  out  1  combinational; the write is taken this cycle.
- full  out  1  registered; count == FIFO_SIZE.
- empty  out  1  registered; count == 0.
- fifo_entries  out  FIFO_SIZE x (NUM_SET_BITS+NUM_TAG_BITS+64)  per physical slot {index, tag, data}, index in the MSBs; invalid slots drive all-zero.
- fifo_valid  out  FIFO_SIZE  per-slot valid mask.
- mem_valid  out  1  head entry is offered to memory.
- mem_addr  out  16  {head tag, head index, 3'b000}.
- mem_data  out  64  head data.
- mem_ready  in  1  memory accepts the head this cycle.

Behaviour:
- Reset: head = tail = 0, count = 0, all slots invalid with zero contents. Outputs during reset: full=0, empty=1, mem_valid=0, fifo_valid=0, all fifo_entries zero.
- Reset is honoured mid-operation; queued entries are discarded and no pop completes on the reset edge.
- Pointers are $clog2(FIFO_SIZE) bits and wrap naturally. count is $clog2(FIFO_SIZE)+1 bits.
- Push: wr_accept = wr_en && !full. When accepted, the slot at tail gets {wr_index, wr_tag, wr_data} and is marked valid, and tail increments.
- Push while full is dropped, even if a pop fires in the same cycle. The producer must hold wr_en until wr_accept is high.
- Pop: mem_valid = !empty. The mem_addr and mem_data outputs are driven combinationally from the head slot registers. On mem_valid && mem_ready the head slot is invalidated and zeroed, and head increments.
- Push and pop in the same cycle: both occur and count is unchanged. When empty, a push is not bypassed to memory; mem_valid rises the next cycle (latency 1 cycle from write to offer).
- The fifo_entries and fifo_valid outputs reflect the registered state only; a push becomes visible to dcache search one cycle after acceptance.
- Duplicate {index, tag} writes create separate entries unless coalescing is enabled.
- mem_ready while empty is ignored.

Optional Feature:
- Macro: WB_FIFO_COALESCE_EN.
- Enabled: a write whose {index, tag} matches a valid slot overwrites that slot's data in place. No new slot is used, wr_accept=1 even when full, and FIFO order is unchanged.
  - Exception: a match on the head slot while it is being popped that cycle does not coalesce and is treated as a normal push.
  - The lookup is a single-match priority search, youngest first.
- Disabled: no compare logic; behaviour exactly as above.

Decomposition:
- Shared package / sys_defs.vh holds:
  - NUM_SET_BITS, NUM_TAG_BITS, FIFO_SIZE defaults;
  - a WB_ENTRY packed struct {index, tag, data[63:0]};
  - an address-build constant for the 3-bit block offset.
- No sub-module is required. If coalescing is enabled, the tag-match comparator may be split into dcache_wb_match (combinational, one-hot hit vector).

Test Plan:
- Reset then idle → empty=1, full=0, mem_valid=0, fifo_valid=8'h00, all entries zero.
- Push {3'b010, 10'h000, 64'hFFFF_FFFF_FFFF_FFF8}, mem_ready=0 → next cycle fifo_valid[0]=1, mem_valid=1, mem_addr=16'h0010, mem_data=64'hFFFF_FFFF_FFFF_FFF8.
- Fill 8 entries with tags 0..7, index 3'b010, mem_ready=0 → full=1; a 9th write gets wr_accept=0 and the entries are unchanged.
- Full FIFO, mem_ready=1 for 8 cycles → addresses leave in push order (0x0010, 0x0050, ... 0x01D0); empty=1 after the 8th; head wraps to 0.
- Push and pop in the same cycle at count=3 → count stays 3; popped slot zeroed; new slot valid at tail.
- Assert reset with 5 entries queued → all outputs return to reset values immediately, with no mem handshake on that edge.
- With WB_FIFO_COALESCE_EN, write tag 10'h009 / index 3'b110 twice with data ...F1 then ...F2 → a single valid entry holding ...F2.
